// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-stated data memory: FSM state encoding,
// default parameter values and the byte-enable width helpers.
package dmem_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_WAIT_CYCLES = 4;
    localparam int DEF_BE_WIDTH    = DEF_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Number of byte lanes in a data word
    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// Request/response bus between a requester (master) and the data memory (slave).
interface data_memory_param_if
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                            req;
    logic                            memwrite;
    logic                            memread;
    logic [ADDR_WIDTH-1:0]           address;
    logic [DATA_WIDTH-1:0]           write_data;
    logic [be_width(DATA_WIDTH)-1:0] byte_en;
    logic                            ready;
    logic [DATA_WIDTH-1:0]           read_data;
    logic                            done;
    logic                            error;

    modport master (
        output req, memwrite, memread, address, write_data, byte_en,
        input  ready, read_data, done, error
    );

    modport slave (
        input  req, memwrite, memread, address, write_data, byte_en,
        output ready, read_data, done, error
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with per-byte write enables. The read port is
// registered and only updates on a read strobe, so it holds the last load.
// Reset clears the read register only; array contents survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic [$clog2(DEPTH)-1:0]        word_idx,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [be_width(DATA_WIDTH)-1:0] wr_be,
    output logic [DATA_WIDTH-1:0]           rd_data
);

    localparam int BE_W = be_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Byte-lane write into the storage array
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem_r[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port, holds its value between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[word_idx];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/data_memory_param.sv
// Wait-stated data memory controller: accepts one command in IDLE, spends
// WAIT_CYCLES cycles in WAIT (array touched on the last one), then pulses
// done for one RESP cycle.
// Optional build macro DATA_MEMORY_PARAM_FAULT_EN: misaligned or out-of-range
// addresses complete with error=1 and no array access. Without it, error is
// tied low, address[1:0] is ignored and addresses wrap modulo DEPTH.
module data_memory_param
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    data_memory_param_if.slave bus
);

    localparam int BE_W  = be_width(DATA_WIDTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    dmem_state_e           state_r;
    dmem_state_e           state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_next_s;
    logic                  ready_r;
    logic                  done_r;
    logic                  error_r;
    logic                  cmd_write_r;
    logic                  cmd_read_r;
    logic [IDX_W-1:0]      idx_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [BE_W-1:0]       be_r;
    logic                  fault_r;
    logic                  fault_s;
    logic                  accept_s;
    logic                  last_wait_s;
    logic                  access_s;
    logic                  we_s;
    logic                  re_s;
    logic [DATA_WIDTH-1:0] rdata_s;

    // ready_r is only ever 1 while the FSM sits in IDLE
    assign accept_s    = bus.req && ready_r;
    assign last_wait_s = (state_r == WAIT) && (cnt_r == CNT_ZERO);
    assign access_s    = last_wait_s && !fault_r;
    // Write wins over read when both commands are set
    assign we_s        = access_s && cmd_write_r && !reset;
    assign re_s        = access_s && cmd_read_r && !cmd_write_r && !reset;

`ifdef DATA_MEMORY_PARAM_FAULT_EN
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH * 4);

    // Misaligned or beyond the last word faults
    always_comb begin
        fault_s = 1'b0;
        if ((bus.address[1:0] != 2'b00) || ({1'b0, bus.address} >= ADDR_LIMIT)) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
    end
`else
    logic addr_unused_s;

    // Low and high address bits play no part without the fault check
    assign addr_unused_s = ^bus.address;

    // No fault detection in this build
    always_comb begin
        fault_s = 1'b0;
    end
`endif

    // Next-state and counter logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = WAIT;
                    cnt_next_s   = CNT_INIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Capture the command fields on accept and hold them for the transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_write_r <= 1'b0;
            cmd_read_r  <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            be_r        <= {BE_W{1'b0}};
            fault_r     <= 1'b0;
        end else if (accept_s) begin
            cmd_write_r <= bus.memwrite;
            cmd_read_r  <= bus.memread;
            idx_r       <= bus.address[IDX_W+1:2];
            wdata_r     <= bus.write_data;
            be_r        <= bus.byte_en;
            fault_r     <= fault_s;
        end else begin
            cmd_write_r <= cmd_write_r;
            cmd_read_r  <= cmd_read_r;
            idx_r       <= idx_r;
            wdata_r     <= wdata_r;
            be_r        <= be_r;
            fault_r     <= fault_r;
        end
    end

    // Registered handshake outputs: ready tracks the upcoming state, done/error
    // pulse for the RESP cycle following the last wait cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            ready_r <= (state_next_s == IDLE);
            done_r  <= last_wait_s;
            error_r <= last_wait_s && fault_r;
        end
    end

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (we_s),
        .rd_en    (re_s),
        .word_idx (idx_r),
        .wr_data  (wdata_r),
        .wr_be    (be_r),
        .rd_data  (rdata_s)
    );

    assign bus.ready     = ready_r;
    assign bus.done      = done_r;
    assign bus.read_data = rdata_s;
`ifdef DATA_MEMORY_PARAM_FAULT_EN
    assign bus.error     = error_r;
`else
    logic error_unused_s;

    assign error_unused_s = error_r;
    assign bus.error      = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_param.sv
// Directed self-checking bench for data_memory_param (WAIT_CYCLES=4, DEPTH=1024).
module tb_data_memory_param;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    data_memory_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    data_memory_param #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .DEPTH       (1024),
        .WAIT_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge; return done latency, ready-low length,
    // and read_data/error seen in the done cycle. Returns at a negedge in IDLE.
    task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           output int lat, output int rlow,
                           output logic [31:0] rd_at_done, output logic err_at_done);
        int n;
        bus.req = 1'b1; bus.memwrite = wr; bus.memread = rd;
        bus.address = addr; bus.write_data = data; bus.byte_en = be;
        n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("accept_ready", 32'(bus.ready), 32'd1);
        @(posedge clock);
        lat = -1; rlow = -1; rd_at_done = 32'hxxxxxxxx; err_at_done = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) bus.req = 1'b0;
            if (bus.done && lat < 0) begin
                lat = k; rd_at_done = bus.read_data; err_at_done = bus.error;
            end
            if (bus.ready && rlow < 0) begin
                rlow = k - 1;
                break;
            end
        end
    endtask

    initial begin
        int lat, rlow, first, second;
        logic [31:0] rdv;
        logic err, done_seen;

        bus.req = 1'b0; bus.memwrite = 1'b0; bus.memread = 1'b0;
        bus.address = 32'd0; bus.write_data = 32'd0; bus.byte_en = 4'd0;

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst_ready", 32'(bus.ready), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_error", 32'(bus.error), 32'd0);
        check_eq("rst_rdata", bus.read_data, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("ready_after_rst", 32'(bus.ready), 32'd1);

        // Full-word write and timing
        run_txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, lat, rlow, rdv, err);
        check_eq("wr_latency", 32'(lat), 32'd5);
        check_eq("wr_ready_low", 32'(rlow), 32'd5);
        check_eq("wr_error", 32'(err), 32'd0);
        run_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("rd_latency", 32'(lat), 32'd5);
        check_eq("rd_0x10", rdv, 32'hDEADBEEF);

        // Word 0 for the wrap test, then byte-enable merge
        run_txn(1'b1, 1'b0, 32'h0, 32'hCAFE0000, 4'hF, lat, rlow, rdv, err);
        run_txn(1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, lat, rlow, rdv, err);
        run_txn(1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'h5, lat, rlow, rdv, err);
        run_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("rd_be_merge", rdv, 32'h11BB33DD);

        // Both commands: write happens, read_data untouched
        run_txn(1'b1, 1'b1, 32'h8, 32'h5, 4'hF, lat, rlow, rdv, err);
        check_eq("rw_done", 32'(lat), 32'd5);
        check_eq("rw_rdata_hold", rdv, 32'h11BB33DD);
        run_txn(1'b0, 1'b1, 32'h8, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("rd_0x8", rdv, 32'h5);

        // No-op, and an all-zero byte_en write
        run_txn(1'b0, 1'b0, 32'h8, 32'hFFFFFFFF, 4'hF, lat, rlow, rdv, err);
        check_eq("noop_latency", 32'(lat), 32'd5);
        check_eq("noop_rdata", rdv, 32'h5);
        run_txn(1'b1, 1'b0, 32'h8, 32'hFFFFFFFF, 4'h0, lat, rlow, rdv, err);
        run_txn(1'b0, 1'b1, 32'h8, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("be0_no_change", rdv, 32'h5);

        // Reset two cycles into a write abandons it
        run_txn(1'b1, 1'b0, 32'h30, 32'h0BADF00D, 4'hF, lat, rlow, rdv, err);
        bus.req = 1'b1; bus.memwrite = 1'b1; bus.memread = 1'b0;
        bus.address = 32'h30; bus.write_data = 32'h12345678; bus.byte_en = 4'hF;
        check_eq("rst_txn_ready", 32'(bus.ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.req = 1'b0;
        done_seen = bus.done;
        @(negedge clock);
        done_seen = done_seen | bus.done;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            done_seen = done_seen | bus.done;
        end
        check_eq("mid_rst_rdata", bus.read_data, 32'd0);
        check_eq("mid_rst_ready", 32'(bus.ready), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_ready_after", 32'(bus.ready), 32'd1);
        check_eq("mid_rst_no_done", 32'(done_seen), 32'd0);
        run_txn(1'b0, 1'b1, 32'h30, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("rd_0x30_old", rdv, 32'h0BADF00D);

`ifdef DATA_MEMORY_PARAM_FAULT_EN
        run_txn(1'b0, 1'b1, 32'h13, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("fault_mis_done", 32'(lat), 32'd5);
        check_eq("fault_mis_error", 32'(err), 32'd1);
        check_eq("fault_mis_rdata", rdv, 32'h0BADF00D);
        run_txn(1'b0, 1'b1, 32'd4096, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("fault_oor_done", 32'(lat), 32'd5);
        check_eq("fault_oor_error", 32'(err), 32'd1);
        check_eq("fault_oor_rdata", rdv, 32'h0BADF00D);
        run_txn(1'b1, 1'b0, 32'd4096, 32'h77777777, 4'hF, lat, rlow, rdv, err);
        run_txn(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("fault_no_write", rdv, 32'hCAFE0000);
        check_eq("ok_error", 32'(err), 32'd0);
`else
        run_txn(1'b0, 1'b1, 32'h13, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("lowbits_ignored", rdv, 32'hDEADBEEF);
        check_eq("nofault_error", 32'(err), 32'd0);
        run_txn(1'b0, 1'b1, 32'd4096, 32'h0, 4'h0, lat, rlow, rdv, err);
        check_eq("wrap_word0", rdv, 32'hCAFE0000);
        check_eq("wrap_error", 32'(err), 32'd0);
`endif

        // req held through RESP is re-accepted in the next IDLE cycle
        bus.req = 1'b1; bus.memwrite = 1'b0; bus.memread = 1'b1;
        bus.address = 32'h20; bus.byte_en = 4'h0;
        check_eq("held_ready", 32'(bus.ready), 32'd1);
        @(posedge clock);
        first = -1; second = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (bus.done) begin
                if (first < 0) begin
                    first = k;
                end else begin
                    second = k;
                    bus.req = 1'b0;
                    break;
                end
            end
        end
        bus.req = 1'b0;
        check_eq("held_first_done", 32'(first), 32'd5);
        check_eq("held_gap", 32'(second - first), 32'd6);
        check_eq("held_rdata", bus.read_data, 32'h11BB33DD);
        for (int k = 0; k < 10 && !bus.ready; k++) @(negedge clock);
        check_eq("held_back_idle", 32'(bus.ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_param.md
DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 Parameter DATA_WIDTH, 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, 32, byte-address width.
REQ-003 Parameter DEPTH, 1024, number of words; SHALL be a power of two.
REQ-004 Parameter WAIT_CYCLES, 4, wait states before array access; minimum 1.
REQ-005 Port clock, input, 1, sole clock; all logic on rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high.
REQ-007 Port req, input, 1, request strobe; accepted when req && ready.
REQ-008 Port memwrite, input, 1, write command, sampled at accept.
REQ-009 Port memread, input, 1, read command, sampled at accept.
REQ-010 Port address, input, ADDR_WIDTH, byte address, sampled at accept.
REQ-011 Port write_data, input, DATA_WIDTH, store data, sampled at accept.
REQ-012 Port byte_en, input, DATA_WIDTH/8, per-byte write enable, sampled at accept.
REQ-013 Port ready, output, 1, high only in IDLE.
REQ-014 Port read_data, output, DATA_WIDTH, registered load data.
REQ-015 Port done, output, 1, one-cycle completion pulse.
REQ-016 Port error, output, 1, access-fault flag, valid only with done.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP.
- IDLE -> WAIT on accept.
- WAIT -> RESP when the wait counter is 0.
- RESP -> IDLE unconditionally.
REQ-018 On accept, the block SHALL latch all command inputs and load the counter with WAIT_CYCLES-1; the counter decrements each WAIT cycle.
REQ-019 The array access SHALL occur on the WAIT cycle where the counter is 0; done SHALL assert in RESP, exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 Word index SHALL be address[log2(DEPTH)+1:2]; address[1:0] selects no lane, and lanes come from byte_en only.
REQ-021 On a write, the block SHALL update only the bytes whose byte_en bit is 1; byte_en of all zeros changes nothing.
REQ-022 On a read, read_data SHALL take the full addressed word and hold it until the next successful read completes.
REQ-023 If memwrite and memread are both 1, the block SHALL perform a write only; read_data is unchanged.
REQ-024 If both are 0, the request SHALL complete as a no-op with done pulsed and no state changed.
REQ-025 Inputs SHALL be ignored while ready is 0; a req held high across RESP is re-accepted on the first IDLE cycle.
REQ-026 A read of a word written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-027 While reset=1, the block SHALL force state=IDLE, counter=0, read_data=0, done=0, error=0; ready becomes 1 on the first cycle after reset deasserts.
REQ-028 Reset SHALL NOT clear array contents.
REQ-029 Reset during WAIT before the access cycle SHALL abandon the transaction with no array write and no done.

Configuration
REQ-030 Macro DATA_MEMORY_PARAM_FAULT_EN.
- Defined: a request SHALL fault if address[1:0]!=0 or address >= DEPTH*4.
- A faulting request SHALL skip the array access, complete with done=1 and error=1, and leave read_data unchanged.
- Undefined: error SHALL be tied 0, address[1:0] SHALL be ignored, and out-of-range addresses SHALL wrap modulo DEPTH.

Structure
REQ-031 Package dmem_pkg SHALL hold the FSM state enum (IDLE/WAIT/RESP), default parameter constants, and the byte-enable width constant.
REQ-032 Sub-module dmem_array SHALL implement the single-port synchronous RAM with byte-write enables.
REQ-033 data_memory_param SHALL contain only the FSM, counter, latches and fault check.

Verification
REQ-034 Write test, WAIT_CYCLES=4: write 0xDEADBEEF to address 0x10 with byte_en=0xF.
- Required: ready=0 for 5 cycles, done at accept+5.
- Required: a following read of 0x10 returns 0xDEADBEEF.
REQ-035 Byte-enable test: write 0x11223344 then 0xAABBCCDD to 0x20, the second with byte_en=0x5; a read of 0x20 returns 0x11BB33DD.
REQ-036 Read/write priority test: request with memread=memwrite=1, data 0x5 at 0x8; expect the write to occur and read_data unchanged from its prior value.
REQ-037 Reset test: raise reset at accept+2 of a write to 0x30; expect no done, ready=1 after release, and 0x30 still holding its old value.
REQ-038 Fault test, macro defined: read of 0x13 and read of DEPTH*4; each gives done=1 and error=1 with read_data unchanged. Macro undefined: a read of DEPTH*4 returns word 0.
